// File: rtl/sb_pkg.sv
// Shared sideband receive definitions: default message geometry and the
// per-cycle status record consumed by the status aggregators.
package sb_pkg;

  localparam int SB_MSG_WIDTH            = 128;
  localparam int SB_DEFAULT_IDLE_TIMEOUT = 32;

  typedef struct packed {
    logic overflow;
    logic frame_err;
  } sb_rx_status_t;

endpackage

// File: rtl/sb_sync_fifo.sv
// Small synchronous FIFO with a combinational head, falling-edge state and
// acceptance of a push into a full FIFO when the same edge pops.
module sb_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sb_deser_fifo.sv
// Multi-lane sideband receive deserializer: assembles LSB-first beats into a
// message, aborts stalled partial frames and queues completed words.
module sb_deser_fifo
  import sb_pkg::*;
#(
  parameter int WIDTH        = SB_MSG_WIDTH,
  parameter int LANES        = 1,
  parameter int DEPTH        = 2,
  parameter int IDLE_TIMEOUT = SB_DEFAULT_IDLE_TIMEOUT,
  localparam int BEATS = WIDTH / LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             frame_err
);

  logic [CW-1:0]    beat;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;
  logic [TW-1:0]    idle_cnt;
  logic             last_beat;
  logic             timeout;
  logic             pop;
  logic             full;
  logic             empty;
  sb_rx_status_t    status;

  // The word pushed on the final beat must already contain that beat.
  always_comb begin
    word = shift;
    word[int'(beat) * LANES +: LANES] = in_data;
  end

  assign last_beat = in_valid && (beat == CW'(BEATS - 1));
  assign timeout   = !in_valid && (beat != '0) && (idle_cnt == TW'(IDLE_TIMEOUT - 1));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      shift    <= '0;
      idle_cnt <= '0;
    end else if (in_valid) begin
      shift    <= word;
      beat     <= last_beat ? '0 : beat + 1'b1;
      idle_cnt <= '0;
    end else if (timeout) begin
      beat     <= '0;
      shift    <= '0;
      idle_cnt <= '0;
    end else if (beat != '0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // Status pulses land on the same edge as the event that raised them.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else begin
      status.overflow  <= last_beat && full && !pop;
      status.frame_err <= timeout;
    end
  end

  assign overflow  = status.overflow;
  assign frame_err = status.frame_err;

  sb_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (last_beat),
    .push_data (word),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule

// File: tb/tb_sb_deser_fifo.sv
// Directed bench for sb_deser_fifo: a small 8-bit instance driven from a
// vector table, plus two 128-bit instances exercised by hand-written frames.
module tb_sb_deser_fifo;

  localparam logic [127:0] W1 = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
  localparam logic [127:0] W2 = 128'h55AA55AA_33CC33CC_0FF00FF0_12345678;
  localparam logic [127:0] W3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] F1 = 128'hA0A0A0A0_11111111_22222222_33333333;
  localparam logic [127:0] F2 = 128'hB1B1B1B1_44444444_55555555_66666666;
  localparam logic [127:0] F3 = 128'hC2C2C2C2_77777777_88888888_99999999;
  localparam logic [127:0] F4 = 128'hCAFEF00D_00000001_80000000_FFFF0000;
  localparam logic [127:0] F5 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] F6 = 128'h13579BDF_2468ACE0_0BADC0DE_FACEB00C;
  localparam logic [127:0] W4 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] W5 = 128'hFEEDFACE_C001D00D_1234ABCD_9876FEDC;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Small instance: 8-bit word, 2 lanes (4 beats), depth 2, timeout 3
  logic [1:0] s_in_data;
  logic       s_in_valid;
  logic       s_out_ready;
  logic [7:0] s_out_data;
  logic       s_out_valid;
  logic [1:0] s_level;
  logic       s_overflow;
  logic       s_frame_err;

  // Single-lane instance, depth 2
  logic [0:0]   a_in_data;
  logic         a_in_valid;
  logic         a_out_ready;
  logic [127:0] a_out_data;
  logic         a_out_valid;
  logic [1:0]   a_level;
  logic         a_overflow;
  logic         a_frame_err;

  // Four-lane instance, depth 1
  logic [3:0]   b_in_data;
  logic         b_in_valid;
  logic         b_out_ready;
  logic [127:0] b_out_data;
  logic         b_out_valid;
  logic [0:0]   b_level;
  logic         b_overflow;
  logic         b_frame_err;

  sb_deser_fifo #(.WIDTH(8), .LANES(2), .DEPTH(2), .IDLE_TIMEOUT(3)) dut_s (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .level(s_level), .overflow(s_overflow), .frame_err(s_frame_err)
  );

  sb_deser_fifo #(.WIDTH(128), .LANES(1), .DEPTH(2), .IDLE_TIMEOUT(32)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .level(a_level), .overflow(a_overflow), .frame_err(a_frame_err)
  );

  sb_deser_fifo #(.WIDTH(128), .LANES(4), .DEPTH(1), .IDLE_TIMEOUT(32)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level), .overflow(b_overflow), .frame_err(b_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] el;
    logic       eo;
    logic       ef;
    logic       cd;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic r,
                              input logic ev, input logic [7:0] ed, input logic [1:0] el,
                              input logic eo, input logic ef, input logic cd);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed; t.el = el;
    t.eo = eo; t.ef = ef; t.cd = cd;
    return t;
  endfunction

  // State changes on the falling edge; everything is driven and sampled 1 ns later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    s_in_valid  = t.v;
    s_in_data   = t.d;
    s_out_ready = t.r;
    step();
  endtask

  task automatic sendFrameA(input logic [127:0] w, input int first, input int last);
    for (int i = first; i < last; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = w[i];
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic sendFrameB(input logic [127:0] w, input int first, input int last);
    for (int i = first; i < last; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = w[4*i +: 4];
      step();
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Frames: A=B4, B=1E, C=6C (dropped), D=39 (after abort), E=A5 (push+pop when full)
    vecs[0]  = mk(1, 2'b00, 0, 0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 0);
    vecs[2]  = mk(0, 2'b00, 0, 0, 8'h00, 0, 0, 0, 0);
    vecs[3]  = mk(1, 2'b11, 0, 0, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(1, 2'b10, 0, 1, 8'hB4, 1, 0, 0, 1);
    vecs[5]  = mk(1, 2'b10, 0, 1, 8'hB4, 1, 0, 0, 1);
    vecs[6]  = mk(1, 2'b11, 0, 1, 8'hB4, 1, 0, 0, 1);
    vecs[7]  = mk(1, 2'b01, 0, 1, 8'hB4, 1, 0, 0, 1);
    vecs[8]  = mk(1, 2'b00, 0, 1, 8'hB4, 2, 0, 0, 1);
    vecs[9]  = mk(1, 2'b00, 0, 1, 8'hB4, 2, 0, 0, 1);
    vecs[10] = mk(1, 2'b11, 0, 1, 8'hB4, 2, 0, 0, 1);
    vecs[11] = mk(1, 2'b10, 0, 1, 8'hB4, 2, 0, 0, 1);
    vecs[12] = mk(1, 2'b01, 0, 1, 8'hB4, 2, 1, 0, 1);
    vecs[13] = mk(0, 2'b00, 0, 1, 8'hB4, 2, 0, 0, 1);
    vecs[14] = mk(0, 2'b00, 1, 1, 8'h1E, 1, 0, 0, 1);
    vecs[15] = mk(1, 2'b11, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[16] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[17] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[18] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 1, 1);
    vecs[19] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[20] = mk(1, 2'b01, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[21] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[22] = mk(0, 2'b00, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[23] = mk(1, 2'b10, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[24] = mk(1, 2'b11, 0, 1, 8'h1E, 1, 0, 0, 1);
    vecs[25] = mk(1, 2'b00, 0, 1, 8'h1E, 2, 0, 0, 1);
    vecs[26] = mk(1, 2'b01, 0, 1, 8'h1E, 2, 0, 0, 1);
    vecs[27] = mk(1, 2'b01, 0, 1, 8'h1E, 2, 0, 0, 1);
    vecs[28] = mk(1, 2'b10, 0, 1, 8'h1E, 2, 0, 0, 1);
    vecs[29] = mk(1, 2'b10, 1, 1, 8'h39, 2, 0, 0, 1);
    vecs[30] = mk(0, 2'b00, 1, 1, 8'hA5, 1, 0, 0, 1);
    vecs[31] = mk(0, 2'b00, 1, 0, 8'h00, 0, 0, 0, 0);
    vecs[32] = mk(0, 2'b00, 1, 0, 8'h00, 0, 0, 0, 0);

    s_in_data = '0; s_in_valid = 0; s_out_ready = 0;
    a_in_data = '0; a_in_valid = 0; a_out_ready = 0;
    b_in_data = '0; b_in_valid = 0; b_out_ready = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset s_out_valid", 128'(s_out_valid), 128'(0));
    checkOutput("reset s_level",     128'(s_level),     128'(0));
    checkOutput("reset s_out_data",  128'(s_out_data),  128'(0));
    checkOutput("reset s_overflow",  128'(s_overflow),  128'(0));
    checkOutput("reset s_frame_err", 128'(s_frame_err), 128'(0));
    checkOutput("reset a_out_valid", 128'(a_out_valid), 128'(0));
    step();
    rst = 1'b0;

    // Table-driven small instance
    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d out_valid", i), 128'(s_out_valid), 128'(vecs[i].ev));
      checkOutput($sformatf("vec%0d level", i),     128'(s_level),     128'(vecs[i].el));
      checkOutput($sformatf("vec%0d overflow", i),  128'(s_overflow),  128'(vecs[i].eo));
      checkOutput($sformatf("vec%0d frame_err", i), 128'(s_frame_err), 128'(vecs[i].ef));
      if (vecs[i].cd)
        checkOutput($sformatf("vec%0d out_data", i), 128'(s_out_data), 128'(vecs[i].ed));
    end

    // Basic single-lane capture with the consumer always ready
    a_out_ready = 1'b1;
    sendFrameA(W1, 0, 127);
    checkOutput("A pre-last out_valid", 128'(a_out_valid), 128'(0));
    sendFrameA(W1, 127, 128);
    checkOutput("A last out_valid", 128'(a_out_valid), 128'(1));
    checkOutput("A last out_data",  a_out_data,        W1);
    checkOutput("A last level",     128'(a_level),     128'(1));
    step();
    checkOutput("A drained level",     128'(a_level),     128'(0));
    checkOutput("A drained out_valid", 128'(a_out_valid), 128'(0));

    // Idle timeout after 50 beats, then a clean frame
    a_out_ready = 1'b0;
    sendFrameA(W2, 0, 50);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 31) checkOutput("timeout idle31 frame_err", 128'(a_frame_err), 128'(0));
      if (k == 32) checkOutput("timeout idle32 frame_err", 128'(a_frame_err), 128'(1));
    end
    checkOutput("timeout level", 128'(a_level), 128'(0));
    step();
    checkOutput("timeout pulse end", 128'(a_frame_err), 128'(0));
    sendFrameA(W3, 0, 128);
    checkOutput("post-timeout out_data", a_out_data,    W3);
    checkOutput("post-timeout level",    128'(a_level), 128'(1));
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    checkOutput("post-timeout drain", 128'(a_level), 128'(0));

    // Overflow: three back-to-back frames into a depth-2 FIFO
    sendFrameA(F1, 0, 128);
    sendFrameA(F2, 0, 128);
    checkOutput("ovf F2 level",    128'(a_level),    128'(2));
    checkOutput("ovf F2 overflow", 128'(a_overflow), 128'(0));
    sendFrameA(F3, 0, 128);
    checkOutput("ovf F3 overflow", 128'(a_overflow), 128'(1));
    checkOutput("ovf F3 level",    128'(a_level),    128'(2));
    checkOutput("ovf head F1",     a_out_data,       F1);
    step();
    checkOutput("ovf pulse end", 128'(a_overflow), 128'(0));
    a_out_ready = 1'b1;
    step();
    checkOutput("ovf head F2",   a_out_data,    F2);
    checkOutput("ovf pop level", 128'(a_level), 128'(1));
    step();
    a_out_ready = 1'b0;
    checkOutput("ovf empty level", 128'(a_level), 128'(0));

    // Four lanes with a 10-cycle gap below the timeout
    b_out_ready = 1'b0;
    sendFrameB(W4, 0, 16);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput($sformatf("gap%0d frame_err", k), 128'(b_frame_err), 128'(0));
    end
    sendFrameB(W4, 16, 32);
    checkOutput("gap out_valid", 128'(b_out_valid), 128'(1));
    checkOutput("gap out_data",  b_out_data,        W4);
    checkOutput("gap level",     128'(b_level),     128'(1));

    // Depth 1 full: pop on the edge the next frame completes
    sendFrameB(W5, 0, 31);
    checkOutput("full head stable", b_out_data, W4);
    b_out_ready = 1'b1;
    sendFrameB(W5, 31, 32);
    checkOutput("full same-edge overflow",  128'(b_overflow),  128'(0));
    checkOutput("full same-edge level",     128'(b_level),     128'(1));
    checkOutput("full same-edge out_valid", 128'(b_out_valid), 128'(1));
    checkOutput("full same-edge out_data",  b_out_data,        W5);
    step();
    b_out_ready = 1'b0;
    checkOutput("full drain level", 128'(b_level), 128'(0));

    // Asynchronous reset mid-frame with one entry queued
    sendFrameA(F4, 0, 128);
    checkOutput("pre-reset level", 128'(a_level), 128'(1));
    sendFrameA(F5, 0, 70);
    rst = 1'b1;
    #1;
    checkOutput("rst level",     128'(a_level),     128'(0));
    checkOutput("rst out_valid", 128'(a_out_valid), 128'(0));
    checkOutput("rst out_data",  a_out_data,        128'(0));
    checkOutput("rst overflow",  128'(a_overflow),  128'(0));
    checkOutput("rst frame_err", 128'(a_frame_err), 128'(0));
    step();
    rst = 1'b0;
    sendFrameA(F6, 0, 128);
    checkOutput("post-rst out_valid", 128'(a_out_valid), 128'(1));
    checkOutput("post-rst out_data",  a_out_data,        F6);
    checkOutput("post-rst level",     128'(a_level),     128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
